tdm_demux_4ch: RTL and testbench
================================

Name: tdm_demux_4ch

Overview:
- Receive-side partner of the 4:1 channel multiplexer. It takes a time-division stream on F, one DATA_W-bit word per slot and four slots per frame, and distributes it back onto W0..W3.
- Locks to a frame-sync strobe and flywheels through short sync dropouts.
- Publishes each complete frame atomically with a one-cycle FRAME_VALID strobe.
- Sits between the serial link and the per-channel consumers.

Parameters:
- DATA_W, 1: width of F and of each W output.
- MISS_LIMIT, 3: consecutive missing SYNCs at slot 0 that drop lock. Legal range 1..15.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- F  input  DATA_W  TDM data word for the current slot
- SYNC  input  1  frame marker; high on the slot-0 word
- EN  input  1  slot strobe; F and SYNC are sampled only when EN=1
- W0, W1, W2, W3  output  DATA_W each  registered channel outputs for the last complete frame
- S1, S0  output  1 each  index of the next slot expected (S1 is the MSB)
- LOCK  output  1  high while in the LOCKED state
- FRAME_VALID  output  1  one-cycle pulse when W0..W3 update
- SYNC_ERR  output  1  one-cycle pulse on an out-of-place SYNC

Behaviour:
- Clock and reset: one clock, CLK. Reset is RST_N, asynchronous and active-low.
- Reset values: W0..W3=0, {S1,S0}=0, LOCK=0, FRAME_VALID=0, SYNC_ERR=0, state=HUNT, miss count=0, shadow registers=0.
- Release from reset takes effect on the first CLK edge after RST_N rises.
- Reset mid-frame discards the partial frame. W0..W3 clear immediately (asynchronous).
- EN=0 cycles: hold all state. FRAME_VALID and SYNC_ERR are 0. SYNC is ignored.
- State HUNT:
  - LOCK=0, {S1,S0}=0.
  - EN=1 with SYNC=0: stay in HUNT; F is discarded.
  - EN=1 with SYNC=1: capture F into shadow0, go to slot 1, enter LOCKED, clear miss count.
- State LOCKED, on each EN=1 edge, with slot = {S1,S0}:
  - slot 1..2, SYNC=0: capture F into shadow[slot]; slot increments.
  - slot 3, SYNC=0: W0..W2 take shadow0..2 and W3 takes F, all on the same edge. FRAME_VALID=1 for exactly the following cycle. Slot wraps to 0.
  - slot 1..3, SYNC=1: SYNC_ERR=1 for one cycle. The partial frame is discarded (no W update, no FRAME_VALID). F is captured as shadow0 and slot goes to 1, i.e. realignment. Miss count clears.
  - slot 0, SYNC=1: capture shadow0, slot goes to 1, miss count clears.
  - slot 0, SYNC=0 (missed sync):
    - If miss count+1 < MISS_LIMIT: increment miss count, capture shadow0 normally, slot goes to 1 (flywheel).
    - If miss count+1 = MISS_LIMIT: go to HUNT, discard F, clear miss count, slot=0.
- Latency: W outputs change on the edge that samples slot 3. FRAME_VALID is registered and high for that one cycle only.
- Output stability: W0..W3 change only on FRAME_VALID edges and never show a mix of two frames.
- Shadow contents are not cleared on realignment; slots are overwritten before use.
- Miss counter is 4 bits wide.

Test Plan:
- DATA_W=1, reset then 4 EN cycles with F=1,0,1,1 and SYNC on the first → LOCK=1 after edge 1; after edge 4 W0..W3=1,0,1,1 and FRAME_VALID high for one cycle; {S1,S0} sequence is 1,2,3,0.
- DATA_W=8, two frames A0..A3 then B0..B3 with EN toggling 1,0,1,0 → W holds A0..A3 unchanged through all B slots, then switches atomically to B0..B3; exactly 2 FRAME_VALID pulses.
- Locked, SYNC asserted at slot 2 with F=0x5A → SYNC_ERR pulse, no FRAME_VALID for the aborted frame, {S1,S0}=1, and the next 3 words complete a frame with W0=0x5A.
- MISS_LIMIT=3, frames with SYNC omitted → 1st and 2nd misses keep LOCK=1 with frames still delivered; 3rd miss gives LOCK=0, {S1,S0}=0, and the F word at that edge is not captured.
- RST_N pulled low at slot 2 → W0..W3=0 and LOCK=0 immediately, with no clock edge needed; after release, words without SYNC are ignored until SYNC=1.
- SYNC=1 with EN=0 in HUNT → no lock, no state change.

Source files
------------

// File: rtl/tdm_demux_4ch.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_4ch
//  Description : Four-slot TDM receiver. Locks to a slot-0 frame marker,
//                flywheels through short marker dropouts and publishes each
//                complete frame atomically on W0..W3 with a FRAME_VALID pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_4ch #(
    parameter int DATA_W     = 1,
    parameter int MISS_LIMIT = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] F,
    input  logic              SYNC,
    input  logic              EN,
    output logic [DATA_W-1:0] W0,
    output logic [DATA_W-1:0] W1,
    output logic [DATA_W-1:0] W2,
    output logic [DATA_W-1:0] W3,
    output logic              S1,
    output logic              S0,
    output logic              LOCK,
    output logic              FRAME_VALID,
    output logic              SYNC_ERR
);

    localparam logic [0:0] c_ST_HUNT    = 1'b0;
    localparam logic [0:0] c_ST_LOCKED  = 1'b1;
    localparam logic [4:0] c_MISS_LIMIT = 5'(MISS_LIMIT);

    logic [0:0]        r_state;
    logic [1:0]        r_slot;
    logic [3:0]        r_miss;
    logic              r_frame_valid;
    logic              r_sync_err;
    logic [DATA_W-1:0] r_sh0;
    logic [DATA_W-1:0] r_sh1;
    logic [DATA_W-1:0] r_sh2;
    logic [DATA_W-1:0] r_w0;
    logic [DATA_W-1:0] r_w1;
    logic [DATA_W-1:0] r_w2;
    logic [DATA_W-1:0] r_w3;

    // Decoded slot events for this edge
    logic       w_locked;
    logic       w_start;     // word becomes slot 0 of a (possibly new) frame
    logic       w_cap1;
    logic       w_cap2;
    logic       w_publish;
    logic       w_misalign;
    logic       w_flywheel;
    logic       w_drop;
    logic [4:0] w_miss_inc;

    assign w_locked   = (r_state == c_ST_LOCKED);
    assign w_miss_inc = {1'b0, r_miss} + 5'd1;

    // Classify the current EN slot into exactly one action
    always_comb begin
        w_start    = 1'b0;
        w_cap1     = 1'b0;
        w_cap2     = 1'b0;
        w_publish  = 1'b0;
        w_misalign = 1'b0;
        w_flywheel = 1'b0;
        w_drop     = 1'b0;
        if (EN) begin
            if (!w_locked) begin
                w_start = SYNC;
            end else if (SYNC) begin
                // A marker always realigns; off slot 0 it also aborts the frame
                w_start    = 1'b1;
                w_misalign = (r_slot != 2'd0);
            end else begin
                case (r_slot)
                    2'd0: begin
                        if (w_miss_inc < c_MISS_LIMIT) begin
                            w_start    = 1'b1;
                            w_flywheel = 1'b1;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end
                    2'd1:    w_cap1    = 1'b1;
                    2'd2:    w_cap2    = 1'b1;
                    default: w_publish = 1'b1;
                endcase
            end
        end
    end

    // Lock state, slot pointer, miss counter and one-cycle status pulses
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= c_ST_HUNT;
            r_slot        <= 2'd0;
            r_miss        <= 4'd0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= w_publish;
            r_sync_err    <= w_misalign;
            if (w_start) begin
                r_state <= c_ST_LOCKED;
                r_slot  <= 2'd1;
                r_miss  <= w_flywheel ? w_miss_inc[3:0] : 4'd0;
            end else if (w_drop) begin
                r_state <= c_ST_HUNT;
                r_slot  <= 2'd0;
                r_miss  <= 4'd0;
            end else if (w_cap1 || w_cap2) begin
                r_slot <= r_slot + 2'd1;
            end else if (w_publish) begin
                r_slot <= 2'd0;
            end
        end
    end

    // Shadow registers collect slots 0..2; stale contents are always overwritten before use
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sh0 <= '0;
            r_sh1 <= '0;
            r_sh2 <= '0;
        end else begin
            if (w_start) r_sh0 <= F;
            if (w_cap1)  r_sh1 <= F;
            if (w_cap2)  r_sh2 <= F;
        end
    end

    // Output words move together on the slot-3 edge so a frame is never mixed
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_w0 <= '0;
            r_w1 <= '0;
            r_w2 <= '0;
            r_w3 <= '0;
        end else if (w_publish) begin
            r_w0 <= r_sh0;
            r_w1 <= r_sh1;
            r_w2 <= r_sh2;
            r_w3 <= F;
        end
    end

    assign W0          = r_w0;
    assign W1          = r_w1;
    assign W2          = r_w2;
    assign W3          = r_w3;
    assign S1          = r_slot[1];
    assign S0          = r_slot[0];
    assign LOCK        = w_locked;
    assign FRAME_VALID = r_frame_valid;
    assign SYNC_ERR    = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_4ch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux_4ch
//  Description : Directed self-checking bench for tdm_demux_4ch with a frame
//                scoreboard (DATA_W=8 instance) plus a DATA_W=1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_4ch;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    // DATA_W=8 instance
    logic [7:0] f;
    logic       sync, en;
    logic [7:0] w0, w1, w2, w3;
    logic       s1, s0, lock, fv, serr;

    // DATA_W=1 instance
    logic f_1, sync_1, en_1;
    logic w0_1, w1_1, w2_1, w3_1;
    logic s1_1, s0_1, lock_1, fv_1, serr_1;

    tdm_demux_4ch #(.DATA_W(8), .MISS_LIMIT(3)) dut8 (
        .CLK(CLK), .RST_N(RST_N), .F(f), .SYNC(sync), .EN(en),
        .W0(w0), .W1(w1), .W2(w2), .W3(w3), .S1(s1), .S0(s0),
        .LOCK(lock), .FRAME_VALID(fv), .SYNC_ERR(serr)
    );

    tdm_demux_4ch #(.DATA_W(1), .MISS_LIMIT(3)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .F(f_1), .SYNC(sync_1), .EN(en_1),
        .W0(w0_1), .W1(w1_1), .W2(w2_1), .W3(w3_1), .S1(s1_1), .S0(s0_1),
        .LOCK(lock_1), .FRAME_VALID(fv_1), .SYNC_ERR(serr_1)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int fv_count = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the 8-bit instance; any frame strobe is checked against the scoreboard
    task automatic cyc(input logic e, input logic s, input logic [7:0] d);
        logic [31:0] want;
        en = e; sync = s; f = d;
        @(posedge CLK); #1;
        if (fv === 1'b1) begin
            fv_count++;
            chk("fv_has_expected_frame", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                chk("frame_words", {w0, w1, w2, w3}, want);
            end
        end
    endtask

    task automatic cyc1(input logic e, input logic s, input logic d);
        en_1 = e; sync_1 = s; f_1 = d;
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [31:0] fa, fb;
        RST_N = 1'b0;
        f = '0; sync = 1'b0; en = 1'b0;
        f_1 = 1'b0; sync_1 = 1'b0; en_1 = 1'b0;
        #12;
        chk("rst_w", {w0, w1, w2, w3}, 32'h0);
        chk("rst_lock_slot", {29'b0, lock, s1, s0}, 32'h0);
        chk("rst_pulses", {30'b0, fv, serr}, 32'h0);
        @(negedge CLK); RST_N = 1'b1;

        // HUNT ignores SYNC while EN=0, and data without SYNC
        cyc(1'b0, 1'b1, 8'h77);
        chk("hunt_en0_sync", {29'b0, lock, s1, s0}, 32'h0);
        cyc(1'b1, 1'b0, 8'h77);
        chk("hunt_nosync", {29'b0, lock, s1, s0}, 32'h0);

        // 1-bit instance: F=1,0,1,1
        cyc1(1'b1, 1'b1, 1'b1);
        chk("w1_lock_slot1", {29'b0, lock_1, s1_1, s0_1}, 32'h5);
        cyc1(1'b1, 1'b0, 1'b0);
        chk("w1_slot2", {30'b0, s1_1, s0_1}, 32'h2);
        cyc1(1'b1, 1'b0, 1'b1);
        chk("w1_slot3", {30'b0, s1_1, s0_1}, 32'h3);
        cyc1(1'b1, 1'b0, 1'b1);
        chk("w1_slot0", {30'b0, s1_1, s0_1}, 32'h0);
        chk("w1_words", {28'b0, w0_1, w1_1, w2_1, w3_1}, 32'hB);
        chk("w1_fv_high", {31'b0, fv_1}, 32'h1);
        cyc1(1'b0, 1'b0, 1'b0);
        chk("w1_fv_low", {31'b0, fv_1}, 32'h0);

        // Two frames with EN toggling; W holds frame A through all B slots
        fa = 32'h11223344;
        fb = 32'hA1B2C3D4;
        fv_count = 0;
        cyc(1'b1, 1'b1, fa[31:24]); cyc(1'b0, 1'b0, 8'hFF);
        chk("a_lock", {29'b0, lock, s1, s0}, 32'h5);
        cyc(1'b1, 1'b0, fa[23:16]); cyc(1'b0, 1'b1, 8'hFF);
        cyc(1'b1, 1'b0, fa[15:8]);  cyc(1'b0, 1'b0, 8'hFF);
        exp_q.push_back(fa);
        cyc(1'b1, 1'b0, fa[7:0]);
        chk("a_slot_wrap", {29'b0, lock, s1, s0}, 32'h4);
        cyc(1'b0, 1'b0, 8'hFF);
        chk("a_fv_one_cycle", {31'b0, fv}, 32'h0);
        cyc(1'b1, 1'b1, fb[31:24]); cyc(1'b0, 1'b0, 8'hFF);
        chk("hold_b0", {w0, w1, w2, w3}, fa);
        cyc(1'b1, 1'b0, fb[23:16]); cyc(1'b0, 1'b0, 8'hFF);
        chk("hold_b1", {w0, w1, w2, w3}, fa);
        cyc(1'b1, 1'b0, fb[15:8]);  cyc(1'b0, 1'b0, 8'hFF);
        chk("hold_b2", {w0, w1, w2, w3}, fa);
        exp_q.push_back(fb);
        cyc(1'b1, 1'b0, fb[7:0]);   cyc(1'b0, 1'b0, 8'hFF);
        chk("two_pulses", 32'(fv_count), 32'd2);

        // Misplaced SYNC at slot 2 realigns and aborts the partial frame
        cyc(1'b1, 1'b1, 8'h01);
        cyc(1'b1, 1'b0, 8'h02);
        cyc(1'b1, 1'b1, 8'h5A);
        chk("serr_pulse", {30'b0, serr, fv}, 32'h2);
        chk("serr_slot", {29'b0, lock, s1, s0}, 32'h5);
        cyc(1'b1, 1'b0, 8'h61);
        chk("serr_one_cycle", {31'b0, serr}, 32'h0);
        cyc(1'b1, 1'b0, 8'h62);
        exp_q.push_back(32'h5A616263);
        cyc(1'b1, 1'b0, 8'h63);
        chk("realign_frame_w0", {24'b0, w0}, 32'h5A);

        // Two flywheeled misses still deliver frames, the third drops lock
        cyc(1'b1, 1'b0, 8'hE0);
        chk("miss1_lock", {29'b0, lock, s1, s0}, 32'h5);
        cyc(1'b1, 1'b0, 8'hE1); cyc(1'b1, 1'b0, 8'hE2);
        exp_q.push_back(32'hE0E1E2E3);
        cyc(1'b1, 1'b0, 8'hE3);
        cyc(1'b1, 1'b0, 8'hC0);
        chk("miss2_lock", {29'b0, lock, s1, s0}, 32'h5);
        cyc(1'b1, 1'b0, 8'hC1); cyc(1'b1, 1'b0, 8'hC2);
        exp_q.push_back(32'hC0C1C2C3);
        cyc(1'b1, 1'b0, 8'hC3);
        cyc(1'b1, 1'b0, 8'hEE);
        chk("miss3_unlock", {29'b0, lock, s1, s0}, 32'h0);
        chk("miss3_w_hold", {w0, w1, w2, w3}, 32'hC0C1C2C3);
        cyc(1'b1, 1'b0, 8'h12);
        chk("miss3_hunt", {29'b0, lock, s1, s0}, 32'h0);

        // Asynchronous reset at slot 2 clears outputs without a clock edge
        cyc(1'b1, 1'b1, 8'h31);
        cyc(1'b1, 1'b0, 8'h32);
        #2 RST_N = 1'b0;
        #1;
        chk("async_rst_w", {w0, w1, w2, w3}, 32'h0);
        chk("async_rst_lock", {29'b0, lock, s1, s0}, 32'h0);
        @(negedge CLK); RST_N = 1'b1;
        cyc(1'b1, 1'b0, 8'h41);
        cyc(1'b1, 1'b0, 8'h42);
        chk("post_rst_hunt", {29'b0, lock, s1, s0}, 32'h0);
        cyc(1'b1, 1'b1, 8'h91); cyc(1'b1, 1'b0, 8'h92); cyc(1'b1, 1'b0, 8'h93);
        exp_q.push_back(32'h91929394);
        cyc(1'b1, 1'b0, 8'h94);
        cyc(1'b0, 1'b0, 8'h00);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
